// File: rtl/fifo_to_stream_if.sv
// FIFO pop port plus valid/ready output stream of the fifo_to_stream adapter.
// The master modport is the adapter side; the slave modport is the FIFO/consumer side.
interface fifo_to_stream_if #(
   parameter int unsigned DW = 16
);
   logic          fifo_empty;
   logic          fifo_rd_en;
   logic [DW-1:0] fifo_rd_data;
   logic          m_valid;
   logic          m_ready;
   logic [DW-1:0] m_data;
   logic          m_last;

   modport master (
      input  fifo_empty, fifo_rd_data, m_ready,
      output fifo_rd_en, m_valid, m_data, m_last
   );

   modport slave (
      output fifo_empty, fifo_rd_data, m_ready,
      input  fifo_rd_en, m_valid, m_data, m_last
   );
endinterface

// File: rtl/fifo_to_stream.sv
// Read-side adapter: pops a 1-cycle-latency FIFO into a 2-entry buffer and presents
// a full-rate valid/ready stream with frame tagging (last every FRAME_LEN words) and flush.
module fifo_to_stream #(
   parameter int unsigned DW        = 16,
   parameter int unsigned FRAME_LEN = 64,
   parameter int unsigned CW        = 7
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  flush,
   fifo_to_stream_if.master      bus,
   output logic [CW-1:0]         frame_cnt
);
   localparam logic [CW-1:0] LAST_IDX = CW'(FRAME_LEN - 1);

   logic [1:0]    occ_q, occ_d;
   logic          inflight_q, inflight_d;
   logic [CW-1:0] widx_q, widx_d;
   logic [DW-1:0] head_data_q, head_data_d;
   logic          head_last_q, head_last_d;
   logic [DW-1:0] tail_data_q, tail_data_d;
   logic          tail_last_q, tail_last_d;
   logic [CW-1:0] frame_cnt_q, frame_cnt_d;

   logic          hs;
   logic          rd_en;
   logic          cap;
   logic          cap_last;
   logic [1:0]    occ_after;
   logic [2:0]    pending;

   // State register
   always_ff @(posedge clk) begin
      if (rst) begin
         occ_q       <= '0;
         inflight_q  <= 1'b0;
         widx_q      <= '0;
         head_data_q <= '0;
         head_last_q <= 1'b0;
         tail_data_q <= '0;
         tail_last_q <= 1'b0;
         frame_cnt_q <= '0;
      end else begin
         occ_q       <= occ_d;
         inflight_q  <= inflight_d;
         widx_q      <= widx_d;
         head_data_q <= head_data_d;
         head_last_q <= head_last_d;
         tail_data_q <= tail_data_d;
         tail_last_q <= tail_last_d;
         frame_cnt_q <= frame_cnt_d;
      end
   end

   // Pop decision, handshake shift, capture into next free entry, flush
   always_comb begin
      occ_d       = occ_q;
      inflight_d  = 1'b0;
      widx_d      = widx_q;
      head_data_d = head_data_q;
      head_last_d = head_last_q;
      tail_data_d = tail_data_q;
      tail_last_d = tail_last_q;
      frame_cnt_d = frame_cnt_q;
      cap_last    = 1'b0;

      hs        = (occ_q != 2'd0) && bus.m_ready;
      pending   = 3'(occ_q) + 3'(inflight_q) - 3'(hs);
      rd_en     = !rst && !bus.fifo_empty && !flush && (pending <= 3'd1);
      cap       = inflight_q && !flush;
      occ_after = occ_q - 2'(hs);

      if (hs) begin
         head_data_d = tail_data_q;
         head_last_d = tail_last_q;
         frame_cnt_d = frame_cnt_q + CW'(head_last_q);
      end

      if (cap) begin
         cap_last = (widx_q == LAST_IDX);
         if (occ_after == 2'd0) begin
            head_data_d = bus.fifo_rd_data;
            head_last_d = cap_last;
         end else begin
            tail_data_d = bus.fifo_rd_data;
            tail_last_d = cap_last;
         end
         widx_d = cap_last ? '0 : widx_q + CW'(1);
         occ_d  = occ_after + 2'd1;
      end else begin
         occ_d  = occ_after;
      end

      inflight_d = rd_en;

      if (flush) begin
         occ_d      = '0;
         inflight_d = 1'b0;
         widx_d     = '0;
      end
   end

   assign bus.fifo_rd_en = rd_en;
   assign bus.m_valid    = (occ_q != 2'd0);
   assign bus.m_data     = head_data_q;
   assign bus.m_last     = head_last_q;
   assign frame_cnt      = frame_cnt_q;

endmodule

// File: tb/tb_fifo_to_stream.sv
// Bench for fifo_to_stream: FIFO stimulus model, queue-based reference of the output
// stream checked every cycle, plus directed scenarios pinned with literal expectations.
module tb_fifo_to_stream;
   localparam int unsigned DW = 16;
   localparam int unsigned FL = 4;
   localparam int unsigned CW = 3;

   typedef struct {
      logic [DW-1:0] data;
      bit            last;
      int            rdy;
   } ent_t;

   logic          clk;
   logic          rst;
   logic          flush;
   logic [CW-1:0] frame_cnt;

   fifo_to_stream_if #(.DW(DW)) bus ();

   fifo_to_stream #(.DW(DW), .FRAME_LEN(FL), .CW(CW)) dut (
      .clk       (clk),
      .rst       (rst),
      .flush     (flush),
      .bus       (bus.master),
      .frame_cnt (frame_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int total = 0;
   int bad   = 0;
   int cyc   = 0;

   // stimulus controls
   bit rst_s, flush_s, ready_s;
   logic [DW-1:0] fifo_q[$];
   bit            rd_pending;
   logic [DW-1:0] rd_word;

   // reference model
   ent_t     exp_q[$];
   int       widx_m;
   bit [CW-1:0] exp_fc;
   bit       armed;

   // per-step samples for directed checks
   bit            t_rden, t_valid, t_last, t_hs;
   logic [DW-1:0] t_data;
   logic [CW-1:0] t_fc;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      total++;
      if (act !== req) begin
         bad++;
         $display("FAIL %s: got 0x%0h want 0x%0h (cycle %0d)", name, act, req, cyc);
      end
   endtask

   task automatic step();
      bit   exp_valid, exp_rden, hs;
      int   pend;
      ent_t e;
      @(negedge clk);
      rst            = rst_s;
      flush          = flush_s;
      bus.m_ready    = ready_s;
      bus.fifo_empty = (fifo_q.size() == 0);
      bus.fifo_rd_data = rd_pending ? rd_word : DW'($urandom);
      #1;
      exp_valid = (exp_q.size() > 0) && (exp_q[0].rdy <= cyc);
      hs        = exp_valid && ready_s;
      pend      = int'(exp_q.size()) - (hs ? 1 : 0);
      exp_rden  = !rst_s && !flush_s && (fifo_q.size() != 0) && (pend <= 1);
      if (armed) begin
         chk("m_valid", 32'(bus.m_valid), 32'(exp_valid));
         if (exp_valid) begin
            chk("m_data", 32'(bus.m_data), 32'(exp_q[0].data));
            chk("m_last", 32'(bus.m_last), 32'(exp_q[0].last));
         end
         chk("frame_cnt", 32'(frame_cnt), 32'(exp_fc));
         chk("fifo_rd_en", 32'(bus.fifo_rd_en), 32'(exp_rden));
      end
      t_rden  = bus.fifo_rd_en;
      t_valid = bus.m_valid;
      t_data  = bus.m_data;
      t_last  = bus.m_last;
      t_fc    = frame_cnt;
      t_hs    = bus.m_valid && ready_s;
      if (bus.fifo_rd_en && bus.fifo_empty) chk("pop_while_empty", 32'(1), 32'(0));
      // FIFO responds to the pop with data one cycle later
      rd_pending = 1'b0;
      if (bus.fifo_rd_en && fifo_q.size() != 0) begin
         rd_word    = fifo_q.pop_front();
         rd_pending = 1'b1;
      end
      if (rst_s) begin
         exp_q.delete();
         widx_m = 0;
         exp_fc = '0;
         armed  = 1'b1;
      end else begin
         if (hs) begin
            e = exp_q.pop_front();
            if (e.last) exp_fc = exp_fc + 1'b1;
         end
         if (rd_pending && !flush_s) begin
            exp_q.push_back('{data: rd_word, last: (widx_m == FL - 1), rdy: cyc + 2});
            widx_m = (widx_m + 1) % FL;
         end
         if (flush_s) begin
            exp_q.delete();
            widx_m = 0;
         end
      end
      cyc++;
   endtask

   initial begin
      int n;
      int unsigned mask;
      logic [DW-1:0] saved, first;
      rst = 1'b1; flush = 1'b0;
      bus.m_ready = 1'b0; bus.fifo_empty = 1'b1; bus.fifo_rd_data = '0;
      rd_pending = 1'b0; armed = 1'b0; widx_m = 0; exp_fc = '0;

      // Reset, FIFO preloaded with 1..5
      rst_s = 1; flush_s = 0; ready_s = 1;
      step();
      for (int i = 1; i <= 5; i++) fifo_q.push_back(DW'(i));
      step();
      chk("rst_m_valid", 32'(t_valid), 32'(0));
      chk("rst_m_data", 32'(t_data), 32'(0));
      chk("rst_m_last", 32'(t_last), 32'(0));
      chk("rst_frame_cnt", 32'(t_fc), 32'(0));
      chk("rst_rd_en", 32'(t_rden), 32'(0));
      rst_s = 0;
      for (int k = 0; k < 8; k++) begin
         step();
         chk("pre_rd_en", 32'(t_rden), 32'(k < 5));
         chk("pre_valid", 32'(t_valid), 32'(k >= 2 && k <= 6));
         if (k >= 2 && k <= 6) chk("pre_data", 32'(t_data), 32'(k - 1));
      end

      // 12-word stream, FRAME_LEN = 4
      rst_s = 1; step(); rst_s = 0;
      for (int i = 1; i <= 12; i++) fifo_q.push_back(DW'(16'h100 + i));
      n = 0; mask = 0;
      for (int k = 0; k < 20; k++) begin
         step();
         if (t_hs) begin
            if (t_last) mask |= (32'd1 << n);
            n++;
         end
      end
      chk("frame_words", 32'(n), 32'(12));
      chk("frame_lasts", mask, 32'h888);
      chk("frame_cnt3", 32'(t_fc), 32'(3));

      // Backpressure for 10 cycles mid-burst
      for (int i = 1; i <= 10; i++) fifo_q.push_back(DW'(16'h200 + i));
      n = 0; saved = '0;
      for (int k = 0; k < 4; k++) begin step(); if (t_hs) n++; end
      ready_s = 0;
      for (int k = 0; k < 10; k++) begin
         step();
         if (k == 2) saved = t_data;
      end
      chk("stall_valid", 32'(t_valid), 32'(1));
      chk("stall_rd_en", 32'(t_rden), 32'(0));
      chk("stall_data", 32'(t_data), 32'(saved));
      ready_s = 1;
      for (int k = 0; k < 15; k++) begin step(); if (t_hs) n++; end
      chk("stall_words", 32'(n), 32'(10));

      // FIFO empty after every word
      for (int i = 0; i < 4; i++) begin
         fifo_q.push_back(DW'(16'h300 + i));
         step();
         chk("alt_rd_en", 32'(t_rden), 32'(1));
         step();
         step();
         chk("alt_valid", 32'(t_valid), 32'(1));
         chk("alt_data", 32'(t_data), 32'(16'h300 + i));
         step();
      end

      // Flush two words into a frame with one pop in flight
      rst_s = 1; step(); rst_s = 0;
      for (int i = 1; i <= 6; i++) fifo_q.push_back(DW'(16'h400 + i));
      for (int k = 0; k < 3; k++) step();
      flush_s = 1;
      fifo_q.push_back(DW'(16'h407));
      fifo_q.push_back(DW'(16'h408));
      step();
      chk("flush_hs", 32'(t_hs), 32'(1));
      chk("flush_hs_data", 32'(t_data), 32'(16'h402));
      flush_s = 0;
      step();
      chk("post_flush_valid", 32'(t_valid), 32'(0));
      n = 0; mask = 0; first = '0;
      for (int k = 0; k < 12; k++) begin
         step();
         if (t_hs) begin
            if (n == 0) first = t_data;
            if (t_last) mask |= (32'd1 << n);
            n++;
         end
      end
      chk("flush_first", 32'(first), 32'(16'h404));
      chk("flush_words", 32'(n), 32'(5));
      chk("flush_lasts", mask, 32'h08);
      chk("flush_fc", 32'(t_fc), 32'(1));

      // Randomized traffic with occasional flush and reset
      for (int k = 0; k < 4000; k++) begin
         if (fifo_q.size() < 8 && $urandom_range(0, ((k / 200) % 3) + 1) != 0)
            fifo_q.push_back(DW'($urandom));
         ready_s = ($urandom_range(0, 3) != 0);
         flush_s = ($urandom_range(0, 59) == 0);
         rst_s   = ($urandom_range(0, 499) == 0);
         step();
      end

      // Reset concurrent with flush and a handshake
      rst_s = 0; flush_s = 0; ready_s = 1;
      for (int i = 0; i < 4; i++) fifo_q.push_back(DW'(16'h500 + i));
      for (int k = 0; k < 6; k++) step();
      rst_s = 1; flush_s = 1;
      step();
      chk("rstfl_hs", 32'(t_hs), 32'(1));
      rst_s = 0; flush_s = 0;
      step();
      chk("rstfl_valid", 32'(t_valid), 32'(0));
      chk("rstfl_data", 32'(t_data), 32'(0));
      chk("rstfl_last", 32'(t_last), 32'(0));
      chk("rstfl_fc", 32'(t_fc), 32'(0));
      for (int k = 0; k < 10; k++) step();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
